// File: rtl/sine_lut.sv
// Quarter-wave sine magnitude generator: 129-node table with 6-bit linear interpolation.
// Define SINE_LUT_REG_OUT_EN to register the output (1-cycle latency, async reset to 0).
module sine_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] v,
  output logic [15:0] sv
);

  // Builds one table node, round(32767*sin(pi/2*k/128)), from a fixed-point
  // Taylor series in Q60 so the table needs no external generator.
  function automatic logic [15:0] sineEntry(input int k);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    x    = (128'(k) * 128'h3243F6A8885A308D) >> 8;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    return 16'((sum * 128'd32767 + (128'd1 << 59)) >> 60);
  endfunction

  logic [15:0] sineTable [0:128];

  for (genvar k = 0; k <= 128; k++) begin : g_table
    localparam logic [15:0] ENTRY = sineEntry(k);
    assign sineTable[k] = ENTRY;
  end

  logic [6:0]  idx;
  logic [5:0]  frac;
  logic [7:0]  idxLo;
  logic [7:0]  idxHi;
  logic [15:0] tabLo;
  logic [15:0] tabHi;
  logic [15:0] tabDiff;
  logic [8:0]  diff;
  logic [14:0] prod;
  logic [15:0] interp;

  assign idx   = v[12:6];
  assign frac  = v[5:0];
  assign idxLo = {1'b0, idx};
  assign idxHi = idxLo + 8'd1;
  assign tabLo = sineTable[idxLo];
  assign tabHi = sineTable[idxHi];

  // Adjacent nodes differ by at most 402, so the slope fits in 9 bits
  // and the product in 15; the sum stays within 32767.
  assign tabDiff = tabHi - tabLo;
  assign diff    = tabDiff[8:0];
  assign prod    = {6'd0, diff} * {9'd0, frac};
  assign interp  = tabLo + {7'd0, prod[14:6]};

`ifdef SINE_LUT_REG_OUT_EN
  logic [15:0] sv_q;
  logic [15:0] sv_d;
  logic        unusedTabDiff;

  assign sv_d          = interp;
  assign unusedTabDiff = &{1'b0, tabDiff[15:9]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sv_q <= 16'd0;
    else     sv_q <= sv_d;
  end

  assign sv = sv_q;
`else
  logic unusedInputs;

  assign unusedInputs = &{1'b0, clk, rst, tabDiff[15:9]};
  assign sv           = interp;
`endif

endmodule

// File: tb/tb_sine_lut.sv
// Self-checking bench for sine_lut; compares against a $sin-based reference model.
// Adapts its timing when SINE_LUT_REG_OUT_EN is defined.
module tb_sine_lut;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        rst;
  logic [12:0] v;
  logic [15:0] sv;

  int passCount;
  int checkCount;
  int refTable [0:128];

  sine_lut dut (
    .clk (clk),
    .rst (rst),
    .v   (v),
    .sv  (sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference node and interpolated value straight from the sine definition.
  function automatic int refNode(input int k);
    return $rtoi(32767.0 * $sin(PI * real'(k) / 256.0) + 0.5);
  endfunction

  function automatic int refSine(input int vin);
    int i;
    int f;
    i = vin / 64;
    f = vin % 64;
    return refTable[i] + ((refTable[i + 1] - refTable[i]) * f) / 64;
  endfunction

  // Presents one phase index and returns once the matching output is visible.
  task automatic applyStimulus(input int vin);
`ifdef SINE_LUT_REG_OUT_EN
    @(negedge clk);
    v = 13'(vin);
    @(posedge clk);
    #1;
`else
    v = 13'(vin);
    #2;
`endif
  endtask

  task automatic test_reset;
`ifdef SINE_LUT_REG_OUT_EN
    rst = 1'b1;
    v   = 13'd4096;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (sv !== 16'd0) $display("[TB] FAIL reset_hold: sv=%0d expected 0", sv);
    else passCount++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkCount++;
    if (sv !== 16'd23170) $display("[TB] FAIL first_after_reset: sv=%0d expected 23170", sv);
    else passCount++;
`else
    rst = 1'b1;
    applyStimulus(4096);
    checkCount++;
    if (sv !== 16'd23170) $display("[TB] FAIL comb_ignores_rst: sv=%0d expected 23170", sv);
    else passCount++;
    rst = 1'b0;
    applyStimulus(0);
    checkCount++;
    if (sv !== 16'd0) $display("[TB] FAIL comb_zero: sv=%0d expected 0", sv);
    else passCount++;
`endif
  endtask

  task automatic test_nodes;
    int vins [7];
    int exps [7];
    vins = '{0, 64, 4096, 8128, 32, 8191, 8127};
    exps = '{0, 402, 23170, 32765, 201, 32766, refSine(8127)};
    for (int n = 0; n < 7; n++) begin
      applyStimulus(vins[n]);
      checkCount++;
      if (sv !== 16'(exps[n]))
        $display("[TB] FAIL node v=%0d: sv=%0d expected %0d", vins[n], sv, exps[n]);
      else passCount++;
    end
  endtask

  task automatic test_sweep;
    int prev;
    int errPrint;
    prev     = 0;
    errPrint = 0;
    for (int vin = 0; vin < 8192; vin++) begin
      applyStimulus(vin);
      checkCount++;
      if (sv !== 16'(refSine(vin))) begin
        $display("[TB] FAIL sweep v=%0d: sv=%0d expected %0d", vin, sv, refSine(vin));
      end else passCount++;
      checkCount++;
      if (int'(sv) < prev)
        $display("[TB] FAIL monotonic v=%0d: sv=%0d below previous %0d", vin, sv, prev);
      else passCount++;
      checkCount++;
      if (sv[15] !== 1'b0) $display("[TB] FAIL msb v=%0d: sv[15]=%b expected 0", vin, sv[15]);
      else passCount++;
      prev = int'(sv);
    end
  endtask

  task automatic test_random;
    int vin;
    for (int n = 0; n < 300; n++) begin
      vin = int'($urandom_range(8191, 0));
      applyStimulus(vin);
      checkCount++;
      if (sv !== 16'(refSine(vin)))
        $display("[TB] FAIL random v=%0d: sv=%0d expected %0d", vin, sv, refSine(vin));
      else passCount++;
    end
  endtask

  // Streams one new index per cycle; expected values wait in a queue.
  task automatic test_back_to_back;
    int pend [$];
    int vins [3];
    int exp;
    vins = '{0, 64, 8191};
    for (int n = 0; n < 3 + 40; n++) begin
      int vin;
      vin = (n < 3) ? vins[n] : int'($urandom_range(8191, 0));
`ifdef SINE_LUT_REG_OUT_EN
      @(negedge clk);
      v = 13'(vin);
      pend.push_back(refSine(vin));
      @(posedge clk);
      #1;
`else
      v = 13'(vin);
      pend.push_back(refSine(vin));
      #2;
`endif
      exp = pend.pop_front();
      checkCount++;
      if (sv !== 16'(exp)) $display("[TB] FAIL back_to_back n=%0d: sv=%0d expected %0d", n, sv, exp);
      else passCount++;
    end
  endtask

  task automatic test_midstream_reset;
`ifdef SINE_LUT_REG_OUT_EN
    applyStimulus(4096);
    checkCount++;
    if (sv !== 16'd23170) $display("[TB] FAIL pre_reset: sv=%0d expected 23170", sv);
    else passCount++;
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if (sv !== 16'd0) $display("[TB] FAIL async_reset: sv=%0d expected 0", sv);
    else passCount++;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (sv !== 16'd0) $display("[TB] FAIL reset_held: sv=%0d expected 0", sv);
    else passCount++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkCount++;
    if (sv !== 16'd23170) $display("[TB] FAIL after_reset: sv=%0d expected 23170", sv);
    else passCount++;
`else
    rst = 1'b1;
    applyStimulus(8191);
    checkCount++;
    if (sv !== 16'd32766) $display("[TB] FAIL comb_rst_top: sv=%0d expected 32766", sv);
    else passCount++;
    rst = 1'b0;
`endif
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst        = 1'b1;
    v          = 13'd0;
    for (int k = 0; k <= 128; k++) refTable[k] = refNode(k);
    test_reset();
    test_nodes();
    test_back_to_back();
    test_random();
    test_midstream_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
